// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Memory-mapped CPU front end for the 8N1 UART core. CPU writes are queued
//   in a TX FIFO and handed to the core one byte at a time; bytes the core
//   receives are drained into an RX FIFO for the CPU to read at leisure.
//
// Build option:
//   UART_BRIDGE_IRQ_EN  when defined, irq is a registered
//                       rx_nempty | rx_ovr | tx_ovf; otherwise irq is tied 0.
//
// Parameters:
//   TX_DEPTH, RX_DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   io_wr, io_rd        one-cycle CPU strobes
//   io_addr             0 = data register, 1 = status register
//   io_wdata            CPU write data
//   io_rdata            combinational read data, 0x00 when io_rd = 0
//   irq                 interrupt request
//   uart_wr, uart_tx_data   registered load pulse + byte to the UART core
//   uart_busy           UART core is transmitting
//   uart_rd             registered pulse telling the core its byte was taken
//   uart_rx_data, uart_valid  received byte and its hold flag from the core
//
// Status byte: {3'b0, tx_ovf, tx_idle, rx_ovr, tx_nfull, rx_nempty}
//
// Core handshake: a byte is offered to the core only when uart_busy is low,
// by a one-cycle uart_wr; the following cycle uart_busy is not looked at,
// giving the core an edge to raise it. A received byte is taken whenever
// uart_valid is high, acknowledged by a one-cycle uart_rd; the following
// cycle uart_valid is not looked at, giving the core an edge to drop it.
module uart_fifo_bridge #(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic       io_addr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       irq,
   output logic       uart_wr,
   output logic [7:0] uart_tx_data,
   input  logic       uart_busy,
   output logic       uart_rd,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_valid
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_CAP = (TAW+1)'(TX_DEPTH);
   localparam logic [RAW:0] RX_CAP = (RAW+1)'(RX_DEPTH);

   typedef enum logic {T_IDLE, T_HOLD} tx_state_t;
   typedef enum logic {R_IDLE, R_HOLD} rx_state_t;
   typedef struct packed {
      tx_state_t tx;
      rx_state_t rx;
   } fsm_state_t;

   fsm_state_t state_q, state_d;

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW-1:0] tx_wp, tx_rp;
   logic [TAW:0]   tx_cnt;
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wp, rx_rp;
   logic [RAW:0]   rx_cnt;

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, tx_drop;
   logic rx_take, rx_push, rx_pop, rx_drop;
   logic stat_rd, tx_ovf, rx_ovr, tx_idle;
   logic [7:0] status;

   assign tx_full  = (tx_cnt == TX_CAP);
   assign tx_empty = (tx_cnt == '0);
   assign rx_full  = (rx_cnt == RX_CAP);
   assign rx_empty = (rx_cnt == '0);

   // Full is judged before any same-cycle pop, so a full FIFO drops the byte.
   assign tx_push = io_wr & ~io_addr & ~tx_full;
   assign tx_drop = io_wr & ~io_addr & tx_full;
   assign rx_push = rx_take & ~rx_full;
   assign rx_drop = rx_take & rx_full;
   assign rx_pop  = io_rd & ~io_addr & ~rx_empty;
   assign stat_rd = io_rd & io_addr;

   assign tx_idle = tx_empty & (state_q.tx == T_IDLE) & ~uart_busy;
   assign status  = {3'b000, tx_ovf, tx_idle, rx_ovr, ~tx_full, ~rx_empty};

   // ---------------- FSMs ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= '{tx: T_IDLE, rx: R_IDLE};
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tx_pop  = 1'b0;
      rx_take = 1'b0;
      case (state_q.tx)
         T_IDLE: if (!tx_empty && !uart_busy) begin
            tx_pop     = 1'b1;
            state_d.tx = T_HOLD;
         end
         T_HOLD: state_d.tx = T_IDLE;
      endcase
      // The core is always drained, even when the RX FIFO has no room.
      case (state_q.rx)
         R_IDLE: if (uart_valid) begin
            rx_take    = 1'b1;
            state_d.rx = R_HOLD;
         end
         R_HOLD: state_d.rx = R_IDLE;
      endcase
   end

   // ---------------- TX FIFO ----------------
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= io_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + TAW'(1);
         if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + (TAW+1)'(1);
            2'b01:   tx_cnt <= tx_cnt - (TAW+1)'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + RAW'(1);
         if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + (RAW+1)'(1);
            2'b01:   rx_cnt <= rx_cnt - (RAW+1)'(1);
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   // ---------------- core strobes and sticky flags ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         uart_wr      <= 1'b0;
         uart_rd      <= 1'b0;
         uart_tx_data <= 8'h00;
         tx_ovf       <= 1'b0;
         rx_ovr       <= 1'b0;
      end else begin
         uart_wr <= tx_pop;
         uart_rd <= rx_take;
         if (tx_pop) uart_tx_data <= tx_mem[tx_rp];
         // A status read clears the flags, but an overflow in that same cycle wins.
         tx_ovf <= tx_drop | (tx_ovf & ~stat_rd);
         rx_ovr <= rx_drop | (rx_ovr & ~stat_rd);
      end
   end

   always_comb begin
      io_rdata = 8'h00;
      if (io_rd) begin
         if (io_addr)        io_rdata = status;
         else if (!rx_empty) io_rdata = rx_mem[rx_rp];
      end
   end

`ifdef UART_BRIDGE_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= ~rx_empty | rx_ovr | tx_ovf;
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
`timescale 1ns/1ps
module tb_uart_fifo_bridge;

   localparam int TXD = 16;
   localparam int RXD = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       io_wr = 1'b0, io_rd = 1'b0, io_addr = 1'b0;
   logic [7:0] io_wdata = 8'h00;
   logic [7:0] io_rdata;
   logic       irq, uart_wr, uart_rd;
   logic [7:0] uart_tx_data;
   logic       uart_busy = 1'b0;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_valid = 1'b0;

   uart_fifo_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk(clk), .reset(reset),
      .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .irq(irq),
      .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
      .uart_rd(uart_rd), .uart_rx_data(uart_rx_data), .uart_valid(uart_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Byte queues plus the "one cycle blind after a strobe" rule of each side.
   logic [7:0] tq[$];
   logic [7:0] rq[$];
   logic [7:0] exp_q[$];   // every byte the model has issued to the core, in order
   logic       m_tx_ovf = 1'b0, m_rx_ovr = 1'b0;
   logic       m_tx_hold = 1'b0, m_rx_hold = 1'b0;
   logic       m_wr = 1'b0, m_rd = 1'b0, m_irq = 1'b0;
   logic [7:0] m_tx_data = 8'h00;
   logic       p_irq, p_txf, p_rxf, p_pop, p_rx, p_txdrop, p_rxdrop;

   always @(posedge clk) begin
      if (reset) begin
         tq.delete(); rq.delete();
         m_tx_ovf = 1'b0; m_rx_ovr = 1'b0; m_tx_hold = 1'b0; m_rx_hold = 1'b0;
         m_wr = 1'b0; m_rd = 1'b0; m_irq = 1'b0; m_tx_data = 8'h00;
      end else begin
         p_irq    = (rq.size() != 0) || m_rx_ovr || m_tx_ovf;
         p_txf    = (tq.size() == TXD);
         p_rxf    = (rq.size() == RXD);
         p_pop    = !m_tx_hold && (tq.size() != 0) && !uart_busy;
         p_rx     = !m_rx_hold && uart_valid;
         p_txdrop = 1'b0;
         p_rxdrop = 1'b0;
         if (p_pop) begin
            m_tx_data = tq.pop_front();
            exp_q.push_back(m_tx_data);
         end
         if (io_wr && !io_addr) begin
            if (p_txf) p_txdrop = 1'b1;
            else       tq.push_back(io_wdata);
         end
         if (io_rd && !io_addr && rq.size() != 0) void'(rq.pop_front());
         if (p_rx) begin
            if (p_rxf) p_rxdrop = 1'b1;
            else       rq.push_back(uart_rx_data);
         end
         if (io_rd && io_addr) begin
            m_tx_ovf = 1'b0;
            m_rx_ovr = 1'b0;
         end
         if (p_txdrop) m_tx_ovf = 1'b1;
         if (p_rxdrop) m_rx_ovr = 1'b1;
         m_wr = p_pop;  m_tx_hold = p_pop;
         m_rd = p_rx;   m_rx_hold = p_rx;
         m_irq = p_irq;
      end
   end

   function automatic logic [7:0] exp_rdata();
      logic [7:0] st;
      st = {3'b000, m_tx_ovf, (tq.size() == 0) && !m_tx_hold && !uart_busy,
            m_rx_ovr, tq.size() < TXD, rq.size() != 0};
      if (!io_rd)          return 8'h00;
      if (io_addr)         return st;
      if (rq.size() != 0)  return rq[0];
      return 8'h00;
   endfunction

   // ---------------- scoreboard / per-cycle checker ----------------
   logic [7:0] got_tx[$];
   logic       exp_irq;

   always @(negedge clk) begin
      #2;
`ifdef UART_BRIDGE_IRQ_EN
      exp_irq = m_irq;
`else
      exp_irq = 1'b0;
`endif
      check("uart_wr",  8'(uart_wr), 8'(m_wr));
      check("uart_rd",  8'(uart_rd), 8'(m_rd));
      check("irq",      8'(irq), 8'(exp_irq));
      check("io_rdata", io_rdata, exp_rdata());
      if (uart_wr) begin
         got_tx.push_back(uart_tx_data);
         if (exp_q.size() == 0) check("tx_byte_unexpected", uart_tx_data, 8'hxx);
         else                   check("tx_byte", uart_tx_data, exp_q.pop_front());
      end
   end

   // ---------------- driver: UART core stand-in + CPU strobes ----------------
   int         busy_mode = 0;   // 0 low, 1 high, 2 random, 3 busy for a while after each uart_wr
   int         busy_cnt  = 0;
   logic       rx_lazy   = 1'b0;
   logic [7:0] rx_src[$];

   task automatic step();
      @(negedge clk);
      io_wr = 1'b0; io_rd = 1'b0; io_addr = 1'b0; io_wdata = 8'h00;
      case (busy_mode)
         0: uart_busy = 1'b0;
         1: uart_busy = 1'b1;
         2: uart_busy = 1'($urandom_range(0, 1));
         default: begin
            if (uart_wr) busy_cnt = $urandom_range(1, 5);
            else if (busy_cnt > 0) busy_cnt--;
            uart_busy = (busy_cnt > 0);
         end
      endcase
      if (uart_valid && uart_rd) uart_valid = 1'b0;
      else if (!uart_valid && rx_src.size() != 0 && (!rx_lazy || $urandom_range(0, 3) == 0)) begin
         uart_valid   = 1'b1;
         uart_rx_data = rx_src.pop_front();
      end
   endtask

   task automatic cpu_write(input logic addr, input logic [7:0] d);
      step();
      io_wr = 1'b1; io_addr = addr; io_wdata = d;
   endtask

   task automatic cpu_read(input logic addr, output logic [7:0] d);
      step();
      io_rd = 1'b1; io_addr = addr;
      #1 d = io_rdata;
   endtask

   // Runs until n uart_rd pulses have been seen, within a cycle budget.
   task automatic wait_rd(input int n, input int budget, output int seen);
      seen = 0;
      for (int i = 0; i < budget && seen < n; i++) begin
         step();
         if (uart_rd) seen++;
      end
   endtask

   initial begin
      #2_000_000;
      check("watchdog", 8'h01, 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   logic [7:0] v;
   int         seen, wr_at, wr_cnt, r;

   initial begin
      // reset and status after reset
      repeat (3) step();
      reset = 1'b0;
      cpu_read(1'b1, v);
      check("rst_status", v, 8'h0A);

      // single byte: latency, data, tx_idle while busy
      cpu_write(1'b0, 8'h55);
      wr_at = 0;
      for (int i = 1; i <= 4 && wr_at == 0; i++) begin
         step();
         if (uart_wr) wr_at = i;
      end
      check("wr_latency", 8'(wr_at), 8'd2);
      check("wr_data", uart_tx_data, 8'h55);
      busy_mode = 1; uart_busy = 1'b1;
      cpu_read(1'b1, v);
      check("idle_while_busy", 8'(v[3]), 8'd0);
      busy_mode = 0;
      cpu_read(1'b1, v);
      check("idle_after_busy", 8'(v[3]), 8'd1);

      // TX overflow with busy held
      busy_mode = 1;
      step();
      for (int b = 0; b <= 16; b++) cpu_write(1'b0, 8'(b));
      cpu_read(1'b1, v);
      check("tx_ovf_status", v & 8'h12, 8'h10);
      got_tx.delete();
      busy_mode = 3;
      for (int i = 0; i < 300 && got_tx.size() < 17; i++) step();
      repeat (10) step();
      check("tx_count", 8'(got_tx.size()), 8'd16);
      for (int i = 0; i < 16 && i < got_tx.size(); i++) check("tx_order", got_tx[i], 8'(i));

      // single RX byte
      busy_mode = 0;
      rx_src.push_back(8'hA5);
      wait_rd(2, 10, seen);
      check("rx_one_rd", 8'(seen), 8'd1);
      cpu_read(1'b0, v);
      check("rx_a5", v, 8'hA5);
      cpu_read(1'b0, v);
      check("rx_empty_data", v, 8'h00);
      cpu_read(1'b1, v);
      check("rx_nempty_clr", 8'(v[0]), 8'd0);

      // RX overflow
      for (int i = 0; i < 17; i++) rx_src.push_back(8'(8'hC0 + i));
      wait_rd(17, 100, seen);
      repeat (4) step();
      check("rx17_rd", 8'(seen), 8'd17);
      cpu_read(1'b1, v);
      check("rx_ovr_set", v & 8'h05, 8'h05);
      cpu_read(1'b1, v);
      check("rx_ovr_clr", 8'(v[2]), 8'd0);
      for (int i = 0; i < 16; i++) begin
         cpu_read(1'b0, v);
         check("rx_keep", v, 8'(8'hC0 + i));
      end
      cpu_read(1'b0, v);
      check("rx_drained", v, 8'h00);

      // simultaneous push and pop at occupancy 5
      for (int i = 0; i < 5; i++) rx_src.push_back(8'(8'h10 + i));
      wait_rd(5, 40, seen);
      repeat (2) step();
      rx_src.push_back(8'h15);
      cpu_read(1'b0, v);          // uart_valid rises in this same cycle
      check("rx_sim_head", v, 8'h10);
      for (int i = 0; i < 5; i++) begin
         cpu_read(1'b0, v);
         check("rx_sim_order", v, 8'(8'h11 + i));
      end
      cpu_read(1'b0, v);
      check("rx_sim_empty", v, 8'h00);

      // reset with both FIFOs populated
      busy_mode = 1;
      for (int i = 0; i < 3; i++) cpu_write(1'b0, 8'(8'h30 + i));
      rx_src.push_back(8'h40); rx_src.push_back(8'h41);
      wait_rd(2, 20, seen);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      busy_mode = 0;
      exp_q.delete();
      wr_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (uart_wr) wr_cnt++;
      end
      check("rst_no_wr", 8'(wr_cnt), 8'd0);
      cpu_read(1'b1, v);
      check("rst_status2", v, 8'h0A);
      cpu_read(1'b0, v);
      check("rst_data", v, 8'h00);

`ifdef UART_BRIDGE_IRQ_EN
      rx_src.push_back(8'h77);
      wait_rd(1, 10, seen);
      check("irq_at_push", 8'(irq), 8'd0);
      step();
      check("irq_after_push", 8'(irq), 8'd1);
      cpu_read(1'b0, v);
      step();
      step();
      check("irq_after_empty", 8'(irq), 8'd0);
`endif

      // randomized traffic
      busy_mode = 3;
      rx_lazy   = 1'b1;
      for (int c = 0; c < 2500; c++) begin
         step();
         if (rx_src.size() < 2 && $urandom_range(0, 1) == 0) rx_src.push_back(8'($urandom));
         if ($urandom_range(0, 599) == 0) reset = 1'b1;
         else reset = 1'b0;
         r = $urandom_range(0, 19);
         if (r < 6) begin
            io_wr = 1'b1; io_addr = 1'b0; io_wdata = 8'($urandom);
         end else if (r < ((c < 1250) ? 7 : 11)) begin
            io_rd = 1'b1; io_addr = 1'b0;
         end else if (r < 13) begin
            io_rd = 1'b1; io_addr = 1'b1;
         end else if (r == 13) begin
            io_wr = 1'b1; io_addr = 1'b1; io_wdata = 8'($urandom);
         end
      end
      reset = 1'b0;
      rx_src.delete();
      busy_mode = 0;
      repeat (60) step();
      check("tx_scoreboard_empty", 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
